// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier sequencer for the MUL/MLA/MLS path.
// Holds the CPU in EXEC1 via stall and pulses exec2 when mulresult is valid.
module mul_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic               flush,
    input  logic [WIDTH-1:0]   mul1,
    input  logic [WIDTH-1:0]   mul2,
    output logic               busy,
    output logic               stall,
    output logic               exec2,
    output logic [5:0]         op_tag,
    output logic [2*WIDTH-1:0] mulresult
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]  acc;
    logic           neg;
    logic           mul_op;
    logic           launch;
    logic           last_bit;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        // -2^(W-1) maps onto itself, which is the correct unsigned magnitude
        if (SIGNED != 0 && v[WIDTH-1])
            return -v;
        return v;
    endfunction

    always_comb begin
        mul_op   = (opcode == 6'b011100) || (opcode == 6'b011101) ||
                   (opcode == 6'b011110);
        launch   = (state == IDLE) && start && mul_op && !flush;
        last_bit = (count == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nx = state;
        exec2    = 1'b0;
        unique case (state)
            IDLE: if (launch) state_nx = RUN;
            RUN: begin
                if (flush)
                    state_nx = IDLE;
                else if (last_bit)
                    state_nx = FIX;
            end
            FIX:  state_nx = flush ? IDLE : DONE;
            DONE: begin
                state_nx = IDLE;
                exec2    = !flush;
            end
        endcase
        busy  = (state != IDLE);
        stall = busy && !exec2;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            op_tag    <= '0;
            mulresult <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                op_tag <= opcode;
                mcand  <= mag(mul1);
                mplier <= mag(mul2);
                neg    <= (SIGNED != 0) && (mul1[WIDTH-1] ^ mul2[WIDTH-1]);
                acc    <= '0;
                count  <= '0;
            end else if (state == RUN && !flush) begin
                if (mplier[0])
                    acc <= acc + (PW'(mcand) << count);
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end else if (state == FIX && !flush) begin
                mulresult <= neg ? -acc : acc;
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: timeline model of the signed instance checked
// every cycle, plus directed products with literal expectations.
module tb_mul_sequencer;

    localparam int W = 16;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [5:0]  opcode;
    logic        flush;
    logic [W-1:0] mul1;
    logic [W-1:0] mul2;
    logic        busy;
    logic        stall;
    logic        exec2;
    logic [5:0]  op_tag;
    logic [31:0] mulresult;

    logic        start_u;
    logic        flush_u;
    logic [W-1:0] mul1_u;
    logic [W-1:0] mul2_u;
    logic        busy_u;
    logic        stall_u;
    logic        exec2_u;
    logic [5:0]  op_tag_u;
    logic [31:0] mulresult_u;

    int checks = 0;
    int failures = 0;
    int n_exec2 = 0;

    mul_sequencer #(.WIDTH(W), .SIGNED(1)) dut (
        .clk(clk), .rstn(rstn), .start(start), .opcode(opcode),
        .flush(flush), .mul1(mul1), .mul2(mul2), .busy(busy),
        .stall(stall), .exec2(exec2), .op_tag(op_tag),
        .mulresult(mulresult)
    );

    mul_sequencer #(.WIDTH(W), .SIGNED(0)) dut_u (
        .clk(clk), .rstn(rstn), .start(start_u), .opcode(opcode),
        .flush(flush_u), .mul1(mul1_u), .mul2(mul2_u), .busy(busy_u),
        .stall(stall_u), .exec2(exec2_u), .op_tag(op_tag_u),
        .mulresult(mulresult_u)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Timeline model: age counts cycles since launch; product by arithmetic.
    int          age;
    logic [5:0]  m_tag;
    logic [31:0] m_res;
    logic [31:0] m_prod;

    function automatic logic [31:0] sprod(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = {{16{a[W-1]}}, a};
        sb = {{16{b[W-1]}}, b};
        return sa * sb;
    endfunction

    function automatic logic is_mul(input logic [5:0] op);
        return op == 6'b011100 || op == 6'b011101 || op == 6'b011110;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            age   <= 0;
            m_tag <= '0;
            m_res <= '0;
        end else if (age == 0) begin
            if (start && is_mul(opcode) && !flush) begin
                age    <= 1;
                m_tag  <= opcode;
                m_prod <= sprod(mul1, mul2);
            end
        end else if (flush) begin
            age <= 0;
        end else begin
            if (age == W + 1)
                m_res <= m_prod;
            age <= (age == W + 2) ? 0 : age + 1;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            logic m_busy;
            logic m_exec2;
            m_busy  = (age != 0);
            m_exec2 = (age == W + 2) && !flush;
            chk("model_busy", 64'(busy), 64'(m_busy));
            chk("model_exec2", 64'(exec2), 64'(m_exec2));
            chk("model_stall", 64'(stall), 64'(m_busy && !m_exec2));
            chk("model_op_tag", 64'(op_tag), 64'(m_tag));
            chk("model_mulresult", 64'(mulresult), 64'(m_res));
            if (exec2)
                n_exec2++;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after an edge; start is driven in this cycle.
    task automatic do_mul(input string name, input logic [5:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [31:0] exp);
        int cyc;
        int stalls;
        opcode = op;
        mul1   = a;
        mul2   = b;
        flush  = 1'b0;
        start  = 1'b1;
        next_cyc();
        start  = 1'b0;
        cyc    = 1;
        stalls = 0;
        while (!exec2 && cyc < 40) begin
            if (stall)
                stalls++;
            next_cyc();
            cyc++;
        end
        chk({name, "_exec2_seen"}, 64'(exec2), 64'(1));
        chk({name, "_latency"}, 64'(cyc), 64'(18));
        chk({name, "_stall_cycles"}, 64'(stalls), 64'(17));
        chk({name, "_stall_at_exec2"}, 64'(stall), 64'(0));
        chk({name, "_result"}, 64'(mulresult), 64'(exp));
        chk({name, "_op_tag"}, 64'(op_tag), 64'(op));
    endtask

    initial begin
        int e0;
        int cyc;
        rstn    = 1'b0;
        start   = 1'b0;
        opcode  = '0;
        flush   = 1'b0;
        mul1    = '0;
        mul2    = '0;
        start_u = 1'b0;
        flush_u = 1'b0;
        mul1_u  = '0;
        mul2_u  = '0;
        repeat (2) next_cyc();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_stall", 64'(stall), 64'(0));
        chk("reset_exec2", 64'(exec2), 64'(0));
        chk("reset_op_tag", 64'(op_tag), 64'(0));
        chk("reset_mulresult", 64'(mulresult), 64'(0));
        rstn = 1'b1;
        next_cyc();

        next_cyc();
        do_mul("mul_7x6", 6'b011100, 16'd7, 16'd6, 32'h0000002A);
        next_cyc();
        do_mul("mul_m3x5", 6'b011101, 16'hFFFD, 16'd5, 32'hFFFFFFF1);
        next_cyc();
        do_mul("mul_min_sq", 6'b011110, 16'h8000, 16'h8000, 32'h40000000);
        next_cyc();
        do_mul("mul_min_x1", 6'b011100, 16'h8000, 16'h0001, 32'hFFFF8000);

        // Non-multiply opcode must not launch
        next_cyc();
        e0     = n_exec2;
        opcode = 6'b010100;
        mul1   = 16'd3;
        mul2   = 16'd4;
        start  = 1'b1;
        next_cyc();
        start  = 1'b0;
        chk("add_busy", 64'(busy), 64'(0));
        repeat (20) next_cyc();
        chk("add_no_exec2", 64'(n_exec2 - e0), 64'(0));

        // Flush in RUN cycle 5, relaunch in the very next cycle
        opcode = 6'b011100;
        mul1   = 16'd11;
        mul2   = 16'd13;
        start  = 1'b1;
        e0     = n_exec2;
        for (int c = 1; c <= 5; c++) begin
            next_cyc();
            start = 1'b0;
        end
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        chk("flush_idle", 64'(busy), 64'(0));
        chk("flush_keep_result", 64'(mulresult), 64'(32'hFFFF8000));
        chk("flush_no_exec2", 64'(n_exec2 - e0), 64'(0));
        do_mul("after_flush", 6'b011101, 16'd300, 16'hFFFE, 32'hFFFFFDA8);

        // Restarts at cycles 3 and 17 are ignored
        next_cyc();
        e0     = n_exec2;
        opcode = 6'b011100;
        mul1   = 16'd25;
        mul2   = 16'd4;
        start  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cyc();
            start = (c == 3) || (c == 17);
            if (start) begin
                mul1 = 16'd1000;
                mul2 = 16'd1000;
            end
            if (c == 18) begin
                chk("restart_exec2", 64'(exec2), 64'(1));
                chk("restart_result", 64'(mulresult), 64'(32'd100));
            end
        end
        chk("restart_one_exec2", 64'(n_exec2 - e0), 64'(1));

        next_cyc();
        do_mul("zero_op", 6'b011110, 16'd0, 16'h1234, 32'h00000000);

        // Asynchronous reset in RUN cycle 9
        next_cyc();
        opcode = 6'b011100;
        mul1   = 16'd9;
        mul2   = 16'd9;
        start  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            next_cyc();
            start = 1'b0;
        end
        chk("pre_reset_busy", 64'(busy), 64'(1));
        #2 rstn = 1'b0;
        #1;
        chk("areset_busy", 64'(busy), 64'(0));
        chk("areset_stall", 64'(stall), 64'(0));
        chk("areset_exec2", 64'(exec2), 64'(0));
        chk("areset_op_tag", 64'(op_tag), 64'(0));
        chk("areset_mulresult", 64'(mulresult), 64'(0));
        next_cyc();
        rstn = 1'b1;
        next_cyc();
        do_mul("post_reset", 6'b011100, 16'd100, 16'd200, 32'h00004E20);

        // Unsigned instance
        next_cyc();
        opcode  = 6'b011110;
        mul1_u  = 16'hFFFF;
        mul2_u  = 16'hFFFF;
        start_u = 1'b1;
        next_cyc();
        start_u = 1'b0;
        cyc = 1;
        while (!exec2_u && cyc < 40) begin
            next_cyc();
            cyc++;
        end
        chk("unsigned_latency", 64'(cyc), 64'(18));
        chk("unsigned_result", 64'(mulresult_u), 64'(32'hFFFE0001));
        chk("unsigned_op_tag", 64'(op_tag_u), 64'(6'b011110));

        repeat (3) next_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
